// File: rtl/disk_ctrl_pkg.sv
// Shared definitions for the disk controller: state encoding and address/data widths.
package disk_ctrl_pkg;
  localparam int DISK_AW    = 10;
  localparam int DISK_DW    = 32;
  localparam int SEEK_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_READY   = 2'd2,
    ST_RELEASE = 2'd3
  } disk_state_e;
endpackage

// File: rtl/disk_mem.sv
// Disk word storage: one preload write port, one registered read port.
// Contents are never reset; only the read register clears.
module disk_mem
  import disk_ctrl_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DISK_AW-1:0] waddr,
  input  logic [DISK_DW-1:0] wdata,
  input  logic               re,
  input  logic [DISK_AW-1:0] raddr,
  output logic [DISK_DW-1:0] rdata
);
  // DEPTH is a power of two, so truncating the address gives the mod-DEPTH wrap.
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DISK_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[MEM_AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr[MEM_AW-1:0]];
  end
endmodule

// File: rtl/disk_ctrl.sv
// Disk controller: seek timer and transfer handshake toward the DMA, plus
// preload write gating with rejection flag.
//
// state   | meaning
// IDLE    | waiting for d_init; preload writes accepted
// SEEK    | seek timer running; d_done aborts back to IDLE
// READY   | d_ready high, d_data_out follows d_addr with one-cycle latency
// RELEASE | waiting for d_done and d_init both low before re-arming
module disk_ctrl
  import disk_ctrl_pkg::*;
#(
  parameter int SEEK_CYCLES = 16,
  parameter int DEPTH       = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_init,
  input  logic [DISK_AW-1:0] d_addr,
  input  logic               d_done,
  output logic               d_ready,
  output logic [DISK_DW-1:0] d_data_out,
  output logic               d_busy,
  input  logic               ld_we,
  input  logic [DISK_AW-1:0] ld_addr,
  input  logic [DISK_DW-1:0] ld_data,
  output logic               ld_err
);
  localparam logic [SEEK_CNT_W-1:0] SEEK_LOAD = SEEK_CNT_W'(SEEK_CYCLES - 1);

  disk_state_e           state, state_nxt;
  logic [SEEK_CNT_W-1:0] cnt, cnt_nxt;
  logic                  mem_we, mem_re;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ld_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ld_err <= ld_we && (state != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (d_init) begin
          state_nxt = ST_SEEK;
          cnt_nxt   = SEEK_LOAD;
        end
      end
      ST_SEEK: begin
        // Abort takes priority over the seek completing on the same edge.
        if (d_done) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_READY;
        end else begin
          cnt_nxt = cnt - SEEK_CNT_W'(1);
        end
      end
      ST_READY: begin
        if (d_done) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!d_done && !d_init) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign d_ready = (state == ST_READY);
  assign d_busy  = (state != ST_IDLE);
  assign mem_we  = ld_we && (state == ST_IDLE);
  assign mem_re  = (state == ST_READY);

  disk_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(ld_addr),
    .wdata(ld_data),
    .re   (mem_re),
    .raddr(d_addr),
    .rdata(d_data_out)
  );
endmodule

// File: tb/tb_disk_ctrl.sv
// Directed bench for disk_ctrl: preload/readback table plus hand-written
// sequences for seek timing, abort, release hold-off, rejected writes and reset.
module tb_disk_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_init, d_done;
  logic [9:0]  d_addr;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        d_ready, d_busy, ld_err;
  logic [31:0] d_data_out;
  logic        r1_ready, r1_busy, r1_err;
  logic [31:0] r1_data;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t pl_vec [7];
  vec_t rd_vec [6];

  always #5 clk = ~clk;

  disk_ctrl dut (
    .clk(clk), .rst(rst), .d_init(d_init), .d_addr(d_addr), .d_done(d_done),
    .d_ready(d_ready), .d_data_out(d_data_out), .d_busy(d_busy),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err)
  );

  disk_ctrl #(.SEEK_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .d_init(d_init), .d_addr(d_addr), .d_done(d_done),
    .d_ready(r1_ready), .d_data_out(r1_data), .d_busy(r1_busy),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(r1_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic wait_ready(input string name, input int exp_cyc);
    int cyc = 0;
    while (!d_ready && cyc < 64) begin
      tick();
      cyc++;
    end
    check(name, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pl_vec[0] = '{10'd0,    32'h0000_00A0};
    pl_vec[1] = '{10'd1,    32'h0000_00A1};
    pl_vec[2] = '{10'd2,    32'h0000_00A2};
    pl_vec[3] = '{10'd3,    32'h0000_00A3};
    pl_vec[4] = '{10'd7,    32'h0000_0077};
    pl_vec[5] = '{10'd512,  32'h1234_5678};
    pl_vec[6] = '{10'd1023, 32'hDEAD_BEEF};

    rd_vec[0] = '{10'd2,    32'h0000_00A2};
    rd_vec[1] = '{10'd0,    32'h0000_00A0};
    rd_vec[2] = '{10'd1023, 32'hDEAD_BEEF};
    rd_vec[3] = '{10'd3,    32'h0000_00A3};
    rd_vec[4] = '{10'd512,  32'h1234_5678};
    rd_vec[5] = '{10'd1,    32'h0000_00A1};

    rst = 1'b1; d_init = 1'b0; d_done = 1'b0; d_addr = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    tick();
    check_bit("rst_ready", d_ready, 1'b0);
    check_bit("rst_busy", d_busy, 1'b0);
    check_bit("rst_lderr", ld_err, 1'b0);
    check("rst_data", d_data_out, 32'h0);
    rst = 1'b0;

    // preload in IDLE
    for (int i = 0; i < 7; i++) begin
      ld_we = 1'b1; ld_addr = pl_vec[i].addr; ld_data = pl_vec[i].data;
      tick();
      check_bit("preload_lderr", ld_err, 1'b0);
    end
    ld_we = 1'b0;

    // transfer: 16-cycle seek on dut, 1-cycle seek on dut1
    d_init = 1'b1;
    tick();
    d_init = 1'b0;
    check_bit("seek_busy", d_busy, 1'b1);
    check_bit("seek_ready0", d_ready, 1'b0);
    check_bit("sc1_ready_e0", r1_ready, 1'b0);
    tick();
    check_bit("sc1_ready_e1", r1_ready, 1'b1);
    check_bit("sc16_ready_e1", d_ready, 1'b0);
    wait_ready("seek16_cycles", 15);

    for (int i = 0; i < 6; i++) begin
      d_addr = rd_vec[i].addr;
      tick();
      check("read_data", d_data_out, rd_vec[i].data);
      check_bit("read_ready", d_ready, 1'b1);
    end

    // rejected preload while READY
    ld_we = 1'b1; ld_addr = 10'd7; ld_data = 32'h55;
    tick();
    ld_we = 1'b0; d_addr = 10'd7;
    check_bit("ready_lderr", ld_err, 1'b1);
    tick();
    check_bit("lderr_pulse", ld_err, 1'b0);
    check("mem7_kept", d_data_out, 32'h77);

    // d_init held through d_done: stay in RELEASE
    d_init = 1'b1; d_done = 1'b1;
    tick();
    d_done = 1'b0;
    check_bit("rel_ready", d_ready, 1'b0);
    check_bit("rel_busy", d_busy, 1'b1);
    check("rel_hold_data", d_data_out, 32'h77);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("rel_hold_busy", d_busy, 1'b1);
      check_bit("rel_hold_ready", d_ready, 1'b0);
    end
    d_init = 1'b0;
    tick();
    check_bit("rel_to_idle", d_busy, 1'b0);
    tick();
    check_bit("no_retrigger", d_busy, 1'b0);

    // abort at seek cycle 5
    d_init = 1'b1;
    tick();
    d_init = 1'b0;
    check_bit("abort_seek_busy", d_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("abort_seek_ready", d_ready, 1'b0);
    end
    d_done = 1'b1;
    tick();
    d_done = 1'b0;
    check_bit("abort_busy", d_busy, 1'b0);
    check_bit("abort_ready", d_ready, 1'b0);
    check("abort_hold_data", d_data_out, 32'h77);

    // d_init and d_done together in IDLE: seek first, then abort
    d_init = 1'b1; d_done = 1'b1;
    tick();
    d_init = 1'b0;
    check_bit("both_seek", d_busy, 1'b1);
    tick();
    d_done = 1'b0;
    check_bit("both_abort", d_busy, 1'b0);
    tick();

    // preload and d_init in the same IDLE cycle
    ld_we = 1'b1; ld_addr = 10'd9; ld_data = 32'h99; d_init = 1'b1;
    tick();
    ld_we = 1'b0; d_init = 1'b0;
    check_bit("same_cyc_busy", d_busy, 1'b1);
    check_bit("same_cyc_lderr", ld_err, 1'b0);
    wait_ready("seek16_cycles_2", 16);
    d_addr = 10'd9;
    tick();
    check("same_cyc_data", d_data_out, 32'h99);

    // reset during READY
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bit("rst_ready_ready", d_ready, 1'b0);
    check_bit("rst_ready_busy", d_busy, 1'b0);
    check("rst_ready_data", d_data_out, 32'h0);
    tick();
    check_bit("rst_stay_idle", d_busy, 1'b0);
    d_init = 1'b1;
    tick();
    d_init = 1'b0;
    wait_ready("seek16_after_rst", 16);
    d_addr = 10'd3;
    tick();
    check("post_rst_data", d_data_out, 32'hA3);
    d_done = 1'b1;
    tick();
    d_done = 1'b0;
    tick();
    check_bit("final_idle", d_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/disk_ctrl.md
DISK_CTRL -- requirements
Module: disk_ctrl

Interface
REQ-001 SHALL have parameter SEEK_CYCLES, default 16, meaning cycles from accepted d_init to d_ready (legal 1..255).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning words of disk storage, addressed by 10 bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 d_init  input  1  transfer start request from DMA, level-sampled.
REQ-007 d_addr  input  10  word address within disk storage.
REQ-008 d_done  input  1  DMA indicates transfer complete or aborted.
REQ-009 d_ready  output  1  storage readable, d_data_out tracks d_addr.
REQ-010 d_data_out  output  32  registered read data, feeds DMA d_data_in.
REQ-011 d_busy  output  1  high in any state other than IDLE.
REQ-012 ld_we  input  1  preload write strobe from test/boot loader.
REQ-013 ld_addr  input  10  preload word address.
REQ-014 ld_data  input  32  preload write data.
REQ-015 ld_err  output  1  one-cycle pulse when a preload write is rejected.

Function
REQ-016 SHALL implement FSM with states IDLE, SEEK, READY, RELEASE.
REQ-017 IDLE: d_init=1 -> SEEK; seek counter loaded with SEEK_CYCLES-1.
REQ-018 SEEK: counter decrements each cycle; at count 0 -> READY on next edge, so d_ready rises exactly SEEK_CYCLES cycles after the edge sampling d_init.
REQ-019 SEEK: d_done=1 -> IDLE (abort); counter cleared; d_ready never asserts.
REQ-020 READY: d_ready=1; d_data_out <= mem[d_addr] every cycle (1-cycle read latency).
REQ-021 READY: d_done=1 -> RELEASE; d_ready deasserts on the same edge.
REQ-022 RELEASE: wait until d_done=0 AND d_init=0, then -> IDLE; prevents re-trigger by held d_init.
REQ-023 d_init while SEEK, READY or RELEASE SHALL be ignored.
REQ-024 d_done and d_init both high in IDLE: d_init wins, SEEK entered; d_done then handled per REQ-019.
REQ-025 d_data_out SHALL hold its last value outside READY.
REQ-026 ld_we in IDLE: mem[ld_addr] <= ld_data at that edge.
REQ-027 ld_we in any other state: write dropped, ld_err pulses 1 for one cycle.
REQ-028 ld_we and d_init in the same IDLE cycle: write accepted, SEEK entered.
REQ-029 Addresses wrap mod DEPTH; no out-of-range condition exists at DEPTH=1024.
REQ-030 d_busy SHALL equal (state != IDLE), combinational from the state register.

Reset
REQ-031 rst=1: state <= IDLE, counter <= 0, d_ready=0, d_busy=0, ld_err=0, d_data_out=0.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 Reset mid-SEEK or mid-READY SHALL return to IDLE on that edge; a new transfer requires d_init after rst deasserts.

Structure
REQ-034 Shared package SHALL hold the state encoding (IDLE=0, SEEK=1, READY=2, RELEASE=3) and the disk address width constant (10).
REQ-035 Storage SHALL be one sub-module, disk_mem: 1 write port (preload), 1 registered read port, DEPTH x 32.
REQ-036 FSM, seek counter and ld_err logic SHALL reside in disk_ctrl.

Verification
REQ-037 Preload mem[0..3]=0xA0..0xA3 in IDLE; pulse d_init; d_ready=1 at cycle 16; d_addr=2 -> d_data_out=0xA2 next cycle.
REQ-038 SEEK_CYCLES=1: d_init sampled at edge N -> d_ready=1 after edge N+1.
REQ-039 d_done at seek cycle 5 -> IDLE, d_ready stays 0, d_busy falls next edge.
REQ-040 ld_we=1 addr 7 data 0x55 during READY -> ld_err pulse, mem[7] unchanged on readback.
REQ-041 d_init held high through d_done -> stays RELEASE until d_init=0; no second SEEK.
REQ-042 rst=1 during READY -> d_ready=0, d_data_out=0 next edge; preloaded data still readable on next transfer.
